// File: rtl/hb_pkg.sv
// Shared state encoding, default parameter values and active-low enable levels.
// No latency; no flow control.
// No backpressure.
package hb_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_LEN       = 4096;
    localparam int DEF_RAM_BASE  = 0;
    localparam int DEF_VERIFY    = 1;
    localparam int DEF_AUTOSTART = 1;

    // Active-low strobe levels for the ROM/RAM enables
    localparam logic EN_OFF = 1'b1;
    localparam logic EN_ON  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        C_RD,
        C_WR,
        V_RD,
        V_CMP,
        DONE,
        FAIL
    } hb_state_e;

endpackage

// File: rtl/hb_bootloader_if.sv
// Program-store and RAM bus bundle between the bootloader and its memories.
// Combinational read data; no latency inside the bundle.
// No backpressure: memories answer in the same cycle.
interface hb_bootloader_if
    import hb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ce_bar;
    logic [DATA_W-1:0] rom_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_ce_bar;
    logic              ram_we_bar;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output rom_addr,
        output rom_ce_bar,
        input  rom_data,
        output ram_addr,
        output ram_ce_bar,
        output ram_we_bar,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  rom_addr,
        input  rom_ce_bar,
        output rom_data,
        input  ram_addr,
        input  ram_ce_bar,
        input  ram_we_bar,
        input  ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/hb_addr_counter.sv
// Word index with synchronous clear, increment enable and terminal count at LEN-1.
// Count updates one edge after clr/inc; tc is combinational from the count.
// No backpressure.
module hb_addr_counter
    import hb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN    = DEF_LEN
) (
    input  logic              clk,
    input  logic              rst_bar,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] cnt,
    output logic              tc
);

    // LEN may equal 2**ADDR_W, so the last index still fits in ADDR_W bits
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LEN - 1);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/hb_bootloader.sv
// Copies LEN words from the program store into RAM, then optionally reads both back and compares.
// done after 2*LEN edges (copy only) or 4*LEN edges (copy + verify) from the start edge.
// start is ignored while busy; memories are combinational so there is no stall path.
module hb_bootloader
    import hb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LEN       = DEF_LEN,
    parameter int RAM_BASE  = DEF_RAM_BASE,
    parameter int VERIFY    = DEF_VERIFY,
    parameter int AUTOSTART = DEF_AUTOSTART
) (
    input  logic              clk,
    input  logic              rst_bar,
    input  logic              start,
    hb_bootloader_if.master   mem,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(RAM_BASE);

    hb_state_e         state_q,    state_d;
    logic [DATA_W-1:0] buf_q,      buf_d;
    logic [DATA_W-1:0] rbuf_q,     rbuf_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              auto_q,     auto_d;

    logic              cnt_clr;
    logic              cnt_inc;
    logic [ADDR_W-1:0] idx;
    logic              idx_last;
    logic              go;
    logic              rom_ce_bar_c;
    logic              ram_ce_bar_c;
    logic              ram_we_bar_c;

    hb_addr_counter #(
        .ADDR_W (ADDR_W),
        .LEN    (LEN)
    ) u_idx (
        .clk     (clk),
        .rst_bar (rst_bar),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .cnt     (idx),
        .tc      (idx_last)
    );

    // auto_q is only ever set by reset, so it fires on the first edge after release
    assign go = start | auto_q;

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        rbuf_d       = rbuf_q;
        err_addr_d   = err_addr_q;
        auto_d       = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        rom_ce_bar_c = EN_OFF;
        ram_ce_bar_c = EN_OFF;
        ram_we_bar_c = EN_OFF;

        case (state_q)
            IDLE, DONE, FAIL: begin
                if (go) begin
                    state_d    = C_RD;
                    cnt_clr    = 1'b1;
                    err_addr_d = '0;
                end
            end
            C_RD: begin
                rom_ce_bar_c = EN_ON;
                buf_d        = mem.rom_data;
                state_d      = C_WR;
            end
            C_WR: begin
                ram_ce_bar_c = EN_ON;
                ram_we_bar_c = EN_ON;
                if (idx_last) begin
                    if (VERIFY != 0) begin
                        state_d = V_RD;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                    state_d = C_RD;
                end
            end
            V_RD: begin
                rom_ce_bar_c = EN_ON;
                ram_ce_bar_c = EN_ON;
                buf_d        = mem.rom_data;
                rbuf_d       = mem.ram_rdata;
                state_d      = V_CMP;
            end
            V_CMP: begin
                if (buf_q != rbuf_q) begin
                    state_d    = FAIL;
                    err_addr_d = idx;
                end else if (idx_last) begin
                    state_d = DONE;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = V_RD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            rbuf_q     <= '0;
            err_addr_q <= '0;
            auto_q     <= (AUTOSTART != 0);
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            rbuf_q     <= rbuf_d;
            err_addr_q <= err_addr_d;
            auto_q     <= auto_d;
        end
    end

    // Addresses follow the index in every state, giving 0 / RAM_BASE under reset
    assign mem.rom_addr   = idx;
    assign mem.ram_addr   = idx + BASE;
    assign mem.ram_wdata  = buf_q;
    assign mem.rom_ce_bar = rom_ce_bar_c;
    assign mem.ram_ce_bar = ram_ce_bar_c;
    assign mem.ram_we_bar = ram_we_bar_c;

    assign busy     = (state_q == C_RD) || (state_q == C_WR) ||
                      (state_q == V_RD) || (state_q == V_CMP);
    assign done     = (state_q == DONE);
    assign error    = (state_q == FAIL);
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_hb_bootloader.sv
// Four bootloader configurations against bench-side ROM/RAM and a write-log reference model.
module tb_hb_bootloader;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

    typedef struct {
        int k;
        int addr;
        int data;
        int cyc;
    } wr_t;

    logic       clk = 1'b0;
    logic [3:0] rst_v;
    logic [3:0] start_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] error_v;
    logic [AW-1:0] err_v [4];

    logic [DW-1:0] rom_mem [N];
    logic [DW-1:0] ram_mem [4][N];
    wr_t           wr_log [$];
    int            cyc = 0;
    logic          corrupt_go;
    int            corrupt_a;
    int            nchk = 0;
    int            nerr = 0;

    always #5 clk = ~clk;

    hb_bootloader_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();
    hb_bootloader_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();
    hb_bootloader_if #(.ADDR_W(AW), .DATA_W(DW)) m2 ();
    hb_bootloader_if #(.ADDR_W(AW), .DATA_W(DW)) m3 ();

    hb_bootloader #(.DATA_W(DW), .ADDR_W(AW), .LEN(N), .RAM_BASE(0), .VERIFY(0), .AUTOSTART(0)) u0 (
        .clk(clk), .rst_bar(rst_v[0]), .start(start_v[0]), .mem(m0.master),
        .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0]), .err_addr(err_v[0]));
    hb_bootloader #(.DATA_W(DW), .ADDR_W(AW), .LEN(N), .RAM_BASE(14), .VERIFY(1), .AUTOSTART(0)) u1 (
        .clk(clk), .rst_bar(rst_v[1]), .start(start_v[1]), .mem(m1.master),
        .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1]), .err_addr(err_v[1]));
    hb_bootloader #(.DATA_W(DW), .ADDR_W(AW), .LEN(1), .RAM_BASE(0), .VERIFY(0), .AUTOSTART(0)) u2 (
        .clk(clk), .rst_bar(rst_v[2]), .start(start_v[2]), .mem(m2.master),
        .busy(busy_v[2]), .done(done_v[2]), .error(error_v[2]), .err_addr(err_v[2]));
    hb_bootloader #(.DATA_W(DW), .ADDR_W(AW), .LEN(N), .RAM_BASE(5), .VERIFY(1), .AUTOSTART(1)) u3 (
        .clk(clk), .rst_bar(rst_v[3]), .start(start_v[3]), .mem(m3.master),
        .busy(busy_v[3]), .done(done_v[3]), .error(error_v[3]), .err_addr(err_v[3]));

    assign m0.rom_data  = rom_mem[m0.rom_addr];
    assign m1.rom_data  = rom_mem[m1.rom_addr];
    assign m2.rom_data  = rom_mem[m2.rom_addr];
    assign m3.rom_data  = rom_mem[m3.rom_addr];
    assign m0.ram_rdata = ram_mem[0][m0.ram_addr];
    assign m1.ram_rdata = ram_mem[1][m1.ram_addr];
    assign m2.ram_rdata = ram_mem[2][m2.ram_addr];
    assign m3.ram_rdata = ram_mem[3][m3.ram_addr];

    // RAM models and write log; cyc is the index of the edge being processed
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!m0.ram_ce_bar && !m0.ram_we_bar) begin
            ram_mem[0][m0.ram_addr] <= m0.ram_wdata;
            wr_log.push_back('{0, int'(m0.ram_addr), int'(m0.ram_wdata), cyc});
        end
        if (!m1.ram_ce_bar && !m1.ram_we_bar) begin
            ram_mem[1][m1.ram_addr] <= m1.ram_wdata;
            wr_log.push_back('{1, int'(m1.ram_addr), int'(m1.ram_wdata), cyc});
        end
        if (!m2.ram_ce_bar && !m2.ram_we_bar) begin
            ram_mem[2][m2.ram_addr] <= m2.ram_wdata;
            wr_log.push_back('{2, int'(m2.ram_addr), int'(m2.ram_wdata), cyc});
        end
        if (!m3.ram_ce_bar && !m3.ram_we_bar) begin
            ram_mem[3][m3.ram_addr] <= m3.ram_wdata;
            wr_log.push_back('{3, int'(m3.ram_addr), int'(m3.ram_wdata), cyc});
        end
        if (corrupt_go) begin
            ram_mem[1][corrupt_a] <= ram_mem[1][corrupt_a] ^ 8'h5A;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start so that the next edge E samples it; returns E
    task automatic kick(input int k, output int e);
        start_v[k] = 1'b1;
        e = cyc;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
    endtask

    // Called just after edge E; off counts edges past E until done or error
    task automatic run_to_end(input int k, input int corrupt_off, input int pulse_off, output int off);
        off = 0;
        while (!(done_v[k] || error_v[k]) && off < 300) begin
            corrupt_go = (off == corrupt_off);
            start_v[k] = (off == pulse_off);
            @(posedge clk);
            #1;
            off++;
        end
        corrupt_go = 1'b0;
        start_v[k] = 1'b0;
        chk("run_timeout", (off < 300), 1);
    endtask

    // Reference: word j goes to (base+j) mod 16 with ROM[j], written on edge E+2j+2
    task automatic check_writes(input int k, input int e, input int base, input int n, input string tag);
        int j;
        j = 0;
        foreach (wr_log[i]) begin
            if (wr_log[i].k == k && wr_log[i].cyc >= e) begin
                if (j < n) begin
                    chk({tag, "_addr"}, wr_log[i].addr, (base + j) % N);
                    chk({tag, "_data"}, wr_log[i].data, int'(rom_mem[j]));
                    chk({tag, "_edge"}, wr_log[i].cyc - e, 2 * j + 2);
                end
                j++;
            end
        end
        chk({tag, "_count"}, j, n);
    endtask

    initial begin
        int e;
        int e2;
        int off;

        rst_v      = 4'hF;
        start_v    = 4'h0;
        corrupt_go = 1'b0;
        corrupt_a  = (14 + 5) % N;
        for (int i = 0; i < N; i++) rom_mem[i] = DW'($urandom);
        #2;
        rst_v = 4'h0;
        #1;

        for (int k = 0; k < 4; k++) begin
            chk("rst_busy",  busy_v[k],  0);
            chk("rst_done",  done_v[k],  0);
            chk("rst_error", error_v[k], 0);
            chk("rst_erra",  err_v[k],   0);
        end
        chk("rst_rom_ce", m1.rom_ce_bar, 1);
        chk("rst_ram_ce", m1.ram_ce_bar, 1);
        chk("rst_ram_we", m1.ram_we_bar, 1);
        chk("rst_rom_addr", m1.rom_addr, 0);
        chk("rst_ram_addr1", m1.ram_addr, 14);
        chk("rst_ram_addr3", m3.ram_addr, 5);

        @(posedge clk);
        #1;
        rst_v = 4'b0111;
        repeat (3) @(posedge clk);
        #1;
        chk("no_autostart", busy_v[0], 0);

        // Plain copy, LEN=16, no verify
        kick(0, e);
        chk("u0_busy", busy_v[0], 1);
        run_to_end(0, -1, -1, off);
        chk("u0_latency", off, 2 * N);
        chk("u0_done", done_v[0], 1);
        chk("u0_error", error_v[0], 0);
        check_writes(0, e, 0, N, "u0");
        chk("u0_idle_rom_ce", m0.rom_ce_bar, 1);
        chk("u0_idle_ram_we", m0.ram_we_bar, 1);
        chk("u0_wdata_hold", m0.ram_wdata, rom_mem[N-1]);

        // Single-word copy
        kick(2, e);
        run_to_end(2, -1, -1, off);
        chk("u2_latency", off, 2);
        chk("u2_done", done_v[2], 1);
        check_writes(2, e, 0, 1, "u2");

        // Copy + verify with wrapping base; a start pulse mid-run must be ignored
        kick(1, e);
        run_to_end(1, -1, 10, off);
        chk("u1_latency", off, 4 * N);
        chk("u1_done", done_v[1], 1);
        chk("u1_error", error_v[1], 0);
        check_writes(1, e, 14, N, "u1");

        // Corrupt word index 5 between copy and verify
        kick(1, e);
        run_to_end(1, 2 * N, -1, off);
        chk("u1c_latency", off, 2 * N + 2 * 5 + 2);
        chk("u1c_error", error_v[1], 1);
        chk("u1c_done", done_v[1], 0);
        chk("u1c_erra", err_v[1], 5);
        check_writes(1, e, 14, N, "u1c");

        // Restart from the failed state
        kick(1, e);
        chk("u1r_error", error_v[1], 0);
        chk("u1r_done", done_v[1], 0);
        chk("u1r_erra", err_v[1], 0);
        chk("u1r_busy", busy_v[1], 1);
        run_to_end(1, -1, -1, off);
        chk("u1r_latency", off, 4 * N);
        chk("u1r_done2", done_v[1], 1);

        // Autostart, then reset during the write of index 7
        rst_v[3] = 1'b1;
        e = cyc;
        @(posedge clk);
        #1;
        chk("u3_autostart", busy_v[3], 1);
        repeat (15) @(posedge clk);
        #1;
        chk("u3_wr7_we", m3.ram_we_bar, 0);
        chk("u3_wr7_addr", m3.ram_addr, (5 + 7) % N);
        rst_v[3] = 1'b0;
        #1;
        chk("u3_rst_busy", busy_v[3], 0);
        chk("u3_rst_ram_we", m3.ram_we_bar, 1);
        chk("u3_rst_ram_ce", m3.ram_ce_bar, 1);
        chk("u3_rst_rom_ce", m3.rom_ce_bar, 1);
        chk("u3_rst_rom_addr", m3.rom_addr, 0);
        chk("u3_rst_ram_addr", m3.ram_addr, 5);
        check_writes(3, e, 5, 7, "u3a");
        repeat (3) @(posedge clk);
        #1;
        check_writes(3, e, 5, 7, "u3held");
        rst_v[3] = 1'b1;
        e2 = cyc;
        @(posedge clk);
        #1;
        run_to_end(3, -1, -1, off);
        chk("u3_latency", off, 4 * N);
        chk("u3_done", done_v[3], 1);
        chk("u3_error", error_v[3], 0);
        check_writes(3, e2, 5, N, "u3b");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/hb_bootloader.md
HB_BOOTLOADER -- requirements
Module: hb_bootloader

Interface
REQ-001 Parameter DATA_W, 8, word width of ROM and RAM data.
REQ-002 Parameter ADDR_W, 12, address width of ROM and RAM.
REQ-003 Parameter LEN, 4096, number of words to copy; legal range 1..2**ADDR_W.
REQ-004 Parameter RAM_BASE, 0, RAM destination offset; the RAM address SHALL be (RAM_BASE + index) mod 2**ADDR_W.
REQ-005 Parameter VERIFY, 1, enables the readback-compare pass.
REQ-006 Parameter AUTOSTART, 1, starts the copy automatically after reset release.
REQ-007 Port list:
- clk  in  1  single clock; all state changes on the rising edge
- rst_bar  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle start request
- rom_addr  out  ADDR_W  program-store address
- rom_ce_bar  out  1  program-store enable, active-low
- rom_data  in  DATA_W  program-store word, combinational
- ram_addr  out  ADDR_W  RAM address
- ram_ce_bar  out  1  RAM chip enable, active-low
- ram_we_bar  out  1  RAM write enable, active-low
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, combinational
- busy  out  1  copy or verify in progress
- done  out  1  level; success
- error  out  1  level; verify mismatch
- err_addr  out  ADDR_W  ROM index of the first mismatch

Function
REQ-008 States SHALL be IDLE, C_RD, C_WR, V_RD, V_CMP, DONE, FAIL.
REQ-009 In IDLE, DONE or FAIL, start=1 SHALL move the FSM to C_RD on the same edge and clear the index, done, error and err_addr.
REQ-010 start SHALL be ignored while busy=1.
REQ-011 With AUTOSTART=1, the first edge after rst_bar deasserts SHALL act as a start.
REQ-012 C_RD:
- rom_ce_bar=0, rom_addr=index.
- rom_data SHALL be captured into a DATA_W buffer on the exiting edge.
- The next state SHALL be C_WR.
REQ-013 C_WR:
- ram_ce_bar=0, ram_we_bar=0, ram_addr=RAM_BASE+index, ram_wdata=buffer.
- If index==LEN-1, the next state SHALL be V_RD when VERIFY=1 (index cleared), else DONE.
- Otherwise the index SHALL increment and the next state SHALL be C_RD.
REQ-014 V_RD:
- rom_ce_bar=0, ram_ce_bar=0, ram_we_bar=1; both addresses as in C_RD/C_WR.
- Both words SHALL be captured on the exiting edge.
- The next state SHALL be V_CMP.
REQ-015 V_CMP:
- On mismatch, the next state SHALL be FAIL and err_addr SHALL take the index.
- Otherwise, at index==LEN-1 the next state SHALL be DONE; else the index SHALL increment and the next state SHALL be V_RD.
REQ-016 Latency: from the start-sampling edge E, done SHALL rise after edge E+2*LEN with VERIFY=0, or after edge E+4*LEN with VERIFY=1.
REQ-017 Termination SHALL compare against LEN-1 and never rely on index overflow; LEN=2**ADDR_W SHALL complete correctly.
REQ-018 Outside the active states, rom_ce_bar, ram_ce_bar and ram_we_bar SHALL be 1, and ram_wdata SHALL hold the buffer.
REQ-019 busy SHALL be 1 exactly in C_RD, C_WR, V_RD and V_CMP.
REQ-020 done=1 only in DONE; error=1 only in FAIL; the two SHALL never be 1 together.
REQ-021 ram_we_bar=0 SHALL occur only in C_WR, and only with ram_ce_bar=0.

Reset
REQ-022 While rst_bar=0, asynchronously:
- state=IDLE, index=0, buffers=0.
- busy=0, done=0, error=0, err_addr=0.
- All enables=1, rom_addr=0, ram_addr=RAM_BASE.
REQ-023 Reset asserted mid-copy SHALL abort without any further RAM write; after release, behaviour SHALL follow REQ-011.

Structure
REQ-024 The state enum, the default parameter values and the active-low inactive constants SHALL reside in shared package hb_pkg.
REQ-025 The index SHALL be a sub-module hb_addr_counter (ADDR_W, synchronous clear, increment enable, terminal-count output at LEN-1).

Verification
REQ-026 DATA_W=8, ADDR_W=4, LEN=16, VERIFY=0, AUTOSTART=0; start at edge 0 -> 16 writes with ram_addr = RAM_BASE+i and data equal to ROM[i]; done high after edge 32.
REQ-027 Same configuration with VERIFY=1 and RAM_BASE=14 -> writes to addresses 14, 15, 0..13 (wrap); done after edge 64; error=0.
REQ-028 VERIFY=1; bench corrupts RAM word at index 5 before the verify pass -> error=1, err_addr=5, done=0, no writes during verify.
REQ-029 LEN=1 -> exactly one write; done after edge 2 (VERIFY=0).
REQ-030 rst_bar pulled low during C_WR of index 7 -> outputs take reset values immediately, no further writes; with AUTOSTART=1, the copy restarts from index 0.
REQ-031 start pulsed while busy -> ignored; start pulsed in FAIL -> done/error cleared and a new copy starts.
